// File: rtl/imem_loadable_if.sv
// rtl/imem_loadable_if.sv - load-stream and fetch-port bundle for imem_loadable
//
// Purpose: groups the program-load handshake and the IF-stage fetch port.
// The master side (loader/core) drives the load words and the fetch address;
// the slave side (memory) answers with ld_ready, ld_count and the fetch result.
//
// Signals:
//   ld_start                 master->slave  restart a load while running
//   ld_valid/ld_data/ld_last master->slave  load word stream
//   ld_ready/ld_count        slave->master  load acceptance, words written
//   pc/stall/flush           master->slave  byte fetch address and pipeline control
//   instr/instr_valid/fault  slave->master  registered fetch result
interface imem_loadable_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 6
);
   logic              ld_start;
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic [IDX_W:0]    ld_count;
   logic [31:0]       pc;
   logic              stall;
   logic              flush;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              fault;

   modport master (
      output ld_start, ld_valid, ld_data, ld_last, pc, stall, flush,
      input  ld_ready, ld_count, instr, instr_valid, fault
   );

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last, pc, stall, flush,
      output ld_ready, ld_count, instr, instr_valid, fault
   );
endinterface

// File: rtl/imem_loadable.sv
// rtl/imem_loadable.sv - loadable synchronous-read instruction memory for the IF stage
//
// Purpose: a program is streamed in word by word while in LOAD; in RUN the
// memory serves registered fetches (one cycle latency) with stall/flush and
// flags misaligned or out-of-range byte addresses as faults.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (enters LOAD, clears pointer/count)
//   bus    imem_loadable_if.slave: load stream in, fetch result out
module imem_loadable #(
   parameter int                DEPTH  = 64,
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] NOP    = 32'h0000_0013,
   localparam int               IDX_W  = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           reset,
   imem_loadable_if.slave bus
);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [IDX_W:0]    count_q;
   logic [DATA_W-1:0] instr_q;
   logic              valid_q;
   logic              fault_q;

   // Storage is deliberately not reset; contents survive reset and reloads.
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              load_hs;
   logic [IDX_W-1:0]  fetch_idx;
   logic              fetch_bad;

   assign load_hs   = (state_q == ST_LOAD) && bus.ld_valid;
   assign fetch_idx = bus.pc[IDX_W+1:2];
   // Any byte offset or any address bit above the word index is a fault.
   assign fetch_bad = (bus.pc[1:0] != 2'b00) || (bus.pc[31:IDX_W+2] != '0);

   always_ff @(posedge clk) begin
      if (load_hs && !reset) begin
         mem_q[ptr_q] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_LOAD;
         ptr_q   <= '0;
         count_q <= '0;
         instr_q <= NOP;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_LOAD: begin
               instr_q <= NOP;
               valid_q <= 1'b0;
               fault_q <= 1'b0;
               if (bus.ld_valid) begin
                  // ptr wraps to 0 after the last word; the state change below
                  // guarantees no further writes land there.
                  ptr_q   <= ptr_q + 1'b1;
                  count_q <= count_q + 1'b1;
                  if (bus.ld_last || (ptr_q == IDX_W'(DEPTH - 1))) begin
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (bus.ld_start) begin
                  state_q <= ST_LOAD;
                  ptr_q   <= '0;
                  count_q <= '0;
                  instr_q <= NOP;
                  valid_q <= 1'b0;
                  fault_q <= 1'b0;
               end else if (bus.flush) begin
                  instr_q <= NOP;
                  valid_q <= 1'b0;
                  fault_q <= 1'b0;
               end else if (!bus.stall) begin
                  if (fetch_bad) begin
                     instr_q <= NOP;
                     valid_q <= 1'b0;
                     fault_q <= 1'b1;
                  end else begin
                     instr_q <= mem_q[fetch_idx];
                     valid_q <= 1'b1;
                     fault_q <= 1'b0;
                  end
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   assign bus.ld_ready    = (state_q == ST_LOAD);
   assign bus.ld_count    = count_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.fault       = fault_q;

endmodule
